// File: rtl/pipe_scroller.sv
// Pipe train scroller: scrolls, recycles and scores NUM_PIPES obstacle pipes.
// Slot outputs are rotated so slot 0 is always the next pipe to pass.
module pipe_scroller #(
  parameter int NUM_PIPES = 4,
  parameter int XW        = 11,
  parameter int SCREEN_W  = 640,
  parameter int PIPE_W    = 80,
  parameter int SPACING   = 160,
  parameter int FIRST_R   = 720,
  parameter int BIRD_X    = 320,
  parameter int SPEED_W   = 3,
  parameter int SCORE_W   = 8,
  parameter int GAP_MIN   = 80,
  parameter int GAP_BITS  = 8,
  parameter int YW        = 9,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          ack,
  input  logic                          tick,
  input  logic [SPEED_W-1:0]            speed,
  output logic [NUM_PIPES*XW-1:0]       pipe_r,
  output logic [NUM_PIPES*XW-1:0]       pipe_l,
  output logic [NUM_PIPES*YW-1:0]       gap_y,
  output logic [$clog2(NUM_PIPES)-1:0]  head_idx,
  output logic [SCORE_W-1:0]            score,
  output logic                          score_pulse,
  output logic                          q_initial,
  output logic                          q_scroll,
  output logic                          q_stop
);

  localparam int HW      = $clog2(NUM_PIPES);
  localparam int SPD_MAX = (1 << SPEED_W) - 1;

  localparam logic [XW-1:0] LP_TRAIN = XW'(NUM_PIPES * SPACING);
  localparam logic [XW-1:0] LP_PW    = XW'(PIPE_W);
  localparam logic [XW-1:0] LP_BIRD  = XW'(BIRD_X);
  localparam logic [YW-1:0] LP_GMIN  = YW'(GAP_MIN);

  if (NUM_PIPES < 2 || (NUM_PIPES & (NUM_PIPES - 1)) != 0) begin : g_bad_n
    $error("NUM_PIPES must be a power of 2, at least 2");
  end
  if (SPD_MAX >= SPACING) begin : g_bad_spd
    $error("max speed must stay below SPACING");
  end
  if (NUM_PIPES * SPACING < SCREEN_W + PIPE_W) begin : g_bad_train
    $error("pipe train shorter than screen plus one pipe");
  end
  if (FIRST_R + NUM_PIPES * SPACING >= (1 << XW)) begin : g_bad_xw
    $error("XW too narrow for the pipe train");
  end
  if (GAP_MIN + (1 << GAP_BITS) - 1 >= (1 << YW)) begin : g_bad_yw
    $error("YW too narrow for the gap range");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("LFSR_SEED must be nonzero");
  end

  typedef enum logic [2:0] {
    S_INIT   = 3'b001,
    S_SCROLL = 3'b010,
    S_STOP   = 3'b100
  } state_t;

  state_t               r_state;
  state_t               w_state_nx;
  logic [XW-1:0]        r_x     [NUM_PIPES];
  logic [XW-1:0]        w_x_nx  [NUM_PIPES];
  logic [YW-1:0]        r_gap   [NUM_PIPES];
  logic [YW-1:0]        w_gap_nx[NUM_PIPES];
  logic [HW-1:0]        r_head;
  logic [HW-1:0]        w_head_nx;
  logic [SCORE_W-1:0]   r_score;
  logic [SCORE_W-1:0]   w_score_nx;
  logic                 r_pulse;
  logic                 w_pulse_nx;
  logic [15:0]          r_lfsr;
  logic [15:0]          w_lfsr_nx;
  logic [XW-1:0]        w_spd;
  logic                 w_rec;

  function automatic logic [XW-1:0] f_init_x(input int i);
    return XW'(FIRST_R + i * SPACING);
  endfunction

  // Fibonacci taps 16,14,13,11; feedback shifts in at bit 0
  function automatic logic [15:0] f_lfsr(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  assign w_spd = XW'(speed);

  always_comb begin
    w_state_nx = r_state;
    w_x_nx     = r_x;
    w_gap_nx   = r_gap;
    w_head_nx  = r_head;
    w_score_nx = r_score;
    w_pulse_nx = 1'b0;
    w_lfsr_nx  = r_lfsr;
    w_rec      = 1'b0;
    case (r_state)
      S_INIT: begin
        for (int i = 0; i < NUM_PIPES; i++) begin
          w_x_nx[i]   = f_init_x(i);
          w_gap_nx[i] = LP_GMIN;
        end
        w_head_nx  = '0;
        w_score_nx = '0;
        w_lfsr_nx  = LFSR_SEED;
        if (start) w_state_nx = S_SCROLL;
      end
      S_SCROLL: begin
        if (stop) begin
          w_state_nx = S_STOP;
        end else if (tick && speed != '0) begin
          for (int i = 0; i < NUM_PIPES; i++) begin
            if (r_x[i] <= w_spd) begin
              w_x_nx[i]   = r_x[i] - w_spd + LP_TRAIN;
              w_gap_nx[i] = LP_GMIN + YW'(r_lfsr[GAP_BITS-1:0]);
              w_rec       = 1'b1;
            end else begin
              w_x_nx[i]   = r_x[i] - w_spd;
            end
          end
          if (w_rec) w_lfsr_nx = f_lfsr(r_lfsr);
          // a recycled head lands far right, so it never counts as passed
          if (w_x_nx[r_head] < LP_BIRD) begin
            w_head_nx  = r_head + 1'b1;
            w_pulse_nx = 1'b1;
            if (r_score != '1) w_score_nx = r_score + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (ack) w_state_nx = S_INIT;
      end
      default: begin
        w_state_nx = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_INIT;
      for (int i = 0; i < NUM_PIPES; i++) begin
        r_x[i]   <= f_init_x(i);
        r_gap[i] <= LP_GMIN;
      end
      r_head  <= '0;
      r_score <= '0;
      r_pulse <= 1'b0;
      r_lfsr  <= LFSR_SEED;
    end else begin
      r_state <= w_state_nx;
      r_x     <= w_x_nx;
      r_gap   <= w_gap_nx;
      r_head  <= w_head_nx;
      r_score <= w_score_nx;
      r_pulse <= w_pulse_nx;
      r_lfsr  <= w_lfsr_nx;
    end
  end

  always_comb begin
    pipe_r = '0;
    pipe_l = '0;
    gap_y  = '0;
    for (int k = 0; k < NUM_PIPES; k++) begin
      pipe_r[k*XW +: XW] = r_x[r_head + HW'(k)];
      pipe_l[k*XW +: XW] = (r_x[r_head + HW'(k)] >= LP_PW)
                         ? r_x[r_head + HW'(k)] - LP_PW : '0;
      gap_y[k*YW +: YW]  = r_gap[r_head + HW'(k)];
    end
  end

  assign head_idx    = r_head;
  assign score       = r_score;
  assign score_pulse = r_pulse;
  assign q_initial   = (r_state == S_INIT);
  assign q_scroll    = (r_state == S_SCROLL);
  assign q_stop      = (r_state == S_STOP);

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller: default instance plus a SCORE_W=2 one.
// Expected coordinates are hand-derived from the scroll arithmetic.
module tb_pipe_scroller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, stop, ack, tick;
  logic [2:0]  speed;
  logic [43:0] pipe_r, pipe_l;
  logic [35:0] gap_y;
  logic [1:0]  head_idx;
  logic [7:0]  score;
  logic        score_pulse, q_initial, q_scroll, q_stop;

  logic        start2, stop2, ack2, tick2;
  logic [2:0]  speed2;
  logic [43:0] pipe_r2, pipe_l2;
  logic [35:0] gap_y2;
  logic [1:0]  head_idx2;
  logic [1:0]  score2;
  logic        pulse2, qi2, qs2, qp2;

  pipe_scroller dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .ack(ack),
    .tick(tick), .speed(speed), .pipe_r(pipe_r), .pipe_l(pipe_l),
    .gap_y(gap_y), .head_idx(head_idx), .score(score),
    .score_pulse(score_pulse), .q_initial(q_initial),
    .q_scroll(q_scroll), .q_stop(q_stop)
  );

  pipe_scroller #(.SCORE_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .stop(stop2), .ack(ack2),
    .tick(tick2), .speed(speed2), .pipe_r(pipe_r2), .pipe_l(pipe_l2),
    .gap_y(gap_y2), .head_idx(head_idx2), .score(score2),
    .score_pulse(pulse2), .q_initial(qi2),
    .q_scroll(qs2), .q_stop(qp2)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] sr(input int k);
    return pipe_r[k*11 +: 11];
  endfunction

  function automatic logic [10:0] sl(input int k);
    return pipe_l[k*11 +: 11];
  endfunction

  function automatic logic [8:0] sg(input int k);
    return gap_y[k*9 +: 9];
  endfunction

  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
    end
  endtask

  logic [43:0] rst_r;
  logic [35:0] rst_g;
  logic [43:0] frz_r;
  logic [43:0] frz_l;
  int          pulses;

  initial begin
    rst_r = {11'd1200, 11'd1040, 11'd880, 11'd720};
    rst_g = {4{9'd80}};
    frz_r = {11'd160, 11'd640, 11'd480, 11'd320};
    frz_l = {11'd80, 11'd560, 11'd400, 11'd240};
    reset = 1'b1; start = 0; stop = 0; ack = 0; tick = 0; speed = 3'd4;
    start2 = 0; stop2 = 0; ack2 = 0; tick2 = 0; speed2 = 3'd7;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_qinit", q_initial, 1);
    chk("rst_score", score, 0);
    chk("rst_head", head_idx, 0);
    chk("rst_s0r", sr(0), 720);
    chk("rst_s0l", sl(0), 640);
    chk("rst_s1r", sr(1), 880);
    chk("rst_s3r", sr(3), 1200);
    chk("rst_gap", gap_y, rst_g);

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("scroll_state", q_scroll, 1);

    tick_n(10);
    chk("t10_s0r", sr(0), 680);
    chk("t10_s0l", sl(0), 600);
    chk("t10_s3r", sr(3), 1160);
    chk("t10_score", score, 0);

    tick_n(90);
    chk("t100_score", score, 0);
    chk("t100_pulse", score_pulse, 0);
    chk("t100_s0r", sr(0), 320);

    tick_n(1);
    chk("t101_pulse", score_pulse, 1);
    chk("t101_score", score, 1);
    chk("t101_head", head_idx, 1);
    chk("t101_s0r", sr(0), 476);
    chk("t101_s3r", sr(3), 316);
    @(negedge clk);
    chk("t101_pulse_end", score_pulse, 0);

    tick_n(78);
    chk("t179_score", score, 2);
    chk("t179_head", head_idx, 2);
    chk("t179_p0r", sr(2), 4);

    tick_n(1);
    chk("t180_p0r", sr(2), 640);
    chk("t180_p3r", sr(1), 480);
    chk("t180_p0gap", sg(2), 305);
    chk("t180_p3gap", sg(1), 80);

    tick_n(40);
    chk("t220_head", head_idx, 3);
    chk("t220_score", score, 3);
    chk("t220_pr", pipe_r, frz_r);
    chk("t220_pl", pipe_l, frz_l);
    chk("t220_p1gap", sg(2), 275);
    chk("t220_p0gap", sg(1), 305);

    @(negedge clk) begin stop = 1'b1; tick = 1'b1; end
    @(negedge clk) begin stop = 1'b0; tick = 1'b0; end
    chk("stop_state", q_stop, 1);
    chk("stop_pr", pipe_r, frz_r);
    chk("stop_score", score, 3);
    chk("stop_pulse", score_pulse, 0);

    tick_n(3);
    chk("stop_tick_pr", pipe_r, frz_r);
    chk("stop_tick_head", head_idx, 3);
    chk("stop_tick_gap", sg(2), 275);

    @(negedge clk) ack = 1'b1;
    @(negedge clk) ack = 1'b0;
    chk("ack_state", q_initial, 1);
    @(negedge clk);
    chk("init_pr", pipe_r, rst_r);
    chk("init_gap", gap_y, rst_g);
    chk("init_score", score, 0);
    chk("init_head", head_idx, 0);

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    tick_n(101);
    chk("rs_pre_pulse", score_pulse, 1);
    chk("rs_pre_score", score, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_pr", pipe_r, rst_r);
    chk("arst_gap", gap_y, rst_g);
    chk("arst_score", score, 0);
    chk("arst_head", head_idx, 0);
    chk("arst_pulse", score_pulse, 0);
    chk("arst_state", {q_stop, q_scroll, q_initial}, 3'b001);
    @(negedge clk) reset = 1'b0;

    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    pulses = 0;
    repeat (150) begin
      @(negedge clk) tick2 = 1'b1;
      @(negedge clk) tick2 = 1'b0;
      if (pulse2) pulses++;
    end
    chk("sat_pulses", pulses, 5);
    chk("sat_score", score2, 3);
    chk("sat_head", head_idx2, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_scroller.md
Name: pipe_scroller

Overview:
- Parametrised successor to the fixed 4-pipe X-coordinate manager in Flappy-VGA.
- Holds NUM_PIPES obstacle pipes and scrolls them left by a programmable speed once per frame tick.
- Recycles each pipe that leaves the screen to the right-hand end of the train, with a pseudo-random gap Y from an LFSR.
- Tracks the head pipe (next pipe the bird must pass), counts a saturating score, and feeds the obstacle/collision logic and the VGA renderer.

Parameters:
- NUM_PIPES, 4, number of pipes; power of 2, at least 2.
- XW, 11, width of the X coordinate.
- SCREEN_W, 640, visible width in pixels.
- PIPE_W, 80, pipe width in pixels.
- SPACING, 160, right-edge to right-edge distance between consecutive pipes.
- FIRST_R, 720, right edge of pipe 0 at init.
- BIRD_X, 320, a pipe counts as passed once its right edge is below this value.
- SPEED_W, 3, width of the speed input.
- SCORE_W, 8, width of the score counter.
- GAP_MIN, 80, minimum gap Y.
- GAP_BITS, 8, number of LFSR bits added to GAP_MIN.
- YW, 9, width of gap Y.
- LFSR_SEED, 16'hACE1, LFSR reset and init value; must be nonzero.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  leave INIT and begin scrolling.
- stop  in  1  freeze the game (collision).
- ack  in  1  leave STOP and return to INIT.
- tick  in  1  one-cycle frame-advance enable.
- speed  in  SPEED_W  pixels moved per tick; 0 means frozen.
- pipe_r  out  NUM_PIPES*XW  right edges, slot-ordered; slot k occupies bits [k*XW +: XW].
- pipe_l  out  NUM_PIPES*XW  left edges, slot-ordered.
- gap_y  out  NUM_PIPES*YW  gap Y per slot.
- head_idx  out  log2(NUM_PIPES)  physical index of slot 0.
- score  out  SCORE_W  passed-pipe count.
- score_pulse  out  1  one-cycle pulse on each pass.
- q_initial, q_scroll, q_stop  out  1 each  one-hot state.

Behaviour:
- Clock, reset: clock clk; reset reset, asynchronous, active-high.
- Reset forces:
  - state INIT;
  - r[i] = FIRST_R + i*SPACING;
  - gap[i] = GAP_MIN;
  - head = 0, score = 0, score_pulse = 0;
  - lfsr = LFSR_SEED.
- Reset in the middle of scrolling takes effect immediately, with no partial update.
- Slot mapping: slot k shows physical pipe (head+k) mod NUM_PIPES.
  - pipe_r = r.
  - pipe_l = r - PIPE_W when r >= PIPE_W, otherwise 0.
  - All outputs are combinational from registers, so there is zero extra latency.
- States (one-hot {q_stop, q_scroll, q_initial}):
  - INIT: reloads every reset value on every clock except the state register. start -> SCROLL.
  - SCROLL:
    - If stop=1, go to STOP on this edge. A tick in the same cycle is ignored: coordinates, score and lfsr all hold.
    - Otherwise, on tick=1 with speed=s, for each pipe i:
      - if r[i] <= s: r[i] <= r[i] - s + NUM_PIPES*SPACING (recycle); gap[i] <= GAP_MIN + lfsr[GAP_BITS-1:0] (pre-step value); lfsr steps once;
      - else r[i] <= r[i] - s.
    - Pass check uses the head pipe's new value on the same tick. If new r[head] < BIRD_X:
      - head <= head + 1 (wraps mod NUM_PIPES);
      - score <= score + 1, saturating at 2^SCORE_W - 1;
      - score_pulse = 1 for one cycle. The pulse fires even when the score is saturated.
    - At most one pass per tick.
    - tick=0 or s=0: everything holds, and no pass is possible.
  - STOP: all registers hold. ack -> INIT.
  - Illegal state -> INIT.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Shift left; feedback enters bit 0.
- Legal configuration (checked by elaboration assertions):
  - speed max < SPACING, so at most one recycle per tick;
  - NUM_PIPES*SPACING >= SCREEN_W + PIPE_W;
  - FIRST_R + NUM_PIPES*SPACING < 2^XW;
  - GAP_MIN + 2^GAP_BITS - 1 < 2^YW.
- Arithmetic is XW wide, unsigned; no overflow can occur within a legal configuration.

Test Plan:
- Reset, then idle:
  - q_initial=1, score=0, head_idx=0;
  - slot0 r=720, l=640; slot1 r=880; slot3 r=1200;
  - all gap_y=80.
- Start, then 10 ticks at speed=4 -> slot0 r=680, slot3 r=1160, score=0.
- Continue to tick 101, where pipe0 r=316:
  - score_pulse high for one cycle, score=1, head_idx=1;
  - slot0 r=476 (pipe1).
- Tick 180, where pipe0 goes from r=4 to recycle:
  - pipe0 r=640, pipe3 r=480;
  - pipe0 gap_y = 80 + 0xE1 = 305;
  - lfsr has stepped once.
- stop and tick asserted in the same cycle -> q_stop=1, all coordinates and score unchanged. Further ticks change nothing. ack -> q_initial, and all reset values are restored one cycle later.
- SCORE_W=2 instance, 5 passes -> score sticks at 3 while score_pulse fires 5 times. Asserting reset during scrolling returns every output to its reset value asynchronously.
